// File: rtl/dcache_wb_buffer.sv
// Write-back buffer for evicted dirty lines: single-cycle enqueue, address merge,
// youngest-copy refill lookup, and in-order AXI3 INCR drain over AW/W/B.
module dcache_wb_buffer #(
    parameter int          DEPTH      = 4,
    parameter int          LINE_WORDS = 4,
    parameter logic [3:0]  AXI_ID     = 4'd1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic [31:0]              enq_addr,
    input  logic [LINE_WORDS*32-1:0] enq_data,
    input  logic [31:0]              lookup_addr,
    output logic                     lookup_hit,
    output logic [LINE_WORDS*32-1:0] lookup_data,
    output logic                     empty,
    output logic                     bus_err,
    output logic [3:0]               awid,
    output logic [31:0]              awaddr,
    output logic [7:0]               awlen,
    output logic [2:0]               awsize,
    output logic [1:0]               awburst,
    output logic [1:0]               awlock,
    output logic [3:0]               awcache,
    output logic [2:0]               awprot,
    output logic                     awvalid,
    input  logic                     awready,
    output logic [3:0]               wid,
    output logic [31:0]              wdata,
    output logic [3:0]               wstrb,
    output logic                     wlast,
    output logic                     wvalid,
    input  logic                     wready,
    input  logic [3:0]               bid,
    input  logic [1:0]               bresp,
    input  logic                     bvalid,
    output logic                     bready
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int OFF_W  = $clog2(LINE_WORDS * 4);
    localparam int TAG_W  = 32 - OFF_W;
    localparam int BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    typedef logic [LINE_WORDS-1:0][31:0] line_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [BEAT_W-1:0]   beat_r;
    logic [BEAT_W-1:0]   beat_nxt_s;

    logic [PTR_W-1:0]    head_r;
    logic [PTR_W-1:0]    tail_r;
    logic [CNT_W-1:0]    count_r;
    logic [DEPTH-1:0]    valid_r;
    logic [TAG_W-1:0]    tag_r  [DEPTH];
    line_t               line_r [DEPTH];
    logic                bus_err_r;

    logic [TAG_W-1:0]    enq_tag_s;
    logic [TAG_W-1:0]    lkp_tag_s;
    logic                in_flight_s;
    logic                enq_fire_s;
    logic                alloc_s;
    logic                pop_s;
    logic                merge_hit_s;
    logic [PTR_W-1:0]    merge_idx_s;
    logic [PTR_W-1:0]    wr_idx_s;
    logic [PTR_W-1:0]    age_idx_s [DEPTH];
    logic                lkp_match_s;
    logic                lkp_hit_s;
    line_t               lkp_data_s;
    logic                enq_match_s;
    logic                unused_ok_s;

    assign enq_tag_s   = enq_addr[31:OFF_W];
    assign lkp_tag_s   = lookup_addr[31:OFF_W];
    assign in_flight_s = (state_r != ST_IDLE);
    assign enq_ready   = (count_r != FULL_CNT);
    assign enq_fire_s  = enq_valid & enq_ready;
    assign alloc_s     = enq_fire_s & ~merge_hit_s;
    assign pop_s       = (state_r == ST_B) & bvalid;
    assign wr_idx_s    = merge_hit_s ? merge_idx_s : tail_r;
    assign unused_ok_s = ^{bid, enq_addr[OFF_W-1:0], lookup_addr[OFF_W-1:0]};

    // Merge target search: any valid entry with the same line except the head being drained.
    always_comb begin
        merge_hit_s = 1'b0;
        merge_idx_s = '0;
        enq_match_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            enq_match_s = valid_r[i] && (tag_r[i] == enq_tag_s) &&
                          !(in_flight_s && (PTR_W'(i) == head_r));
            merge_idx_s = enq_match_s ? PTR_W'(i) : merge_idx_s;
            merge_hit_s = merge_hit_s | enq_match_s;
        end
    end

    // Refill probe walks entries oldest to youngest so the youngest match wins.
    always_comb begin
        lkp_hit_s   = 1'b0;
        lkp_data_s  = '0;
        lkp_match_s = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            age_idx_s[k] = head_r + PTR_W'(k);
            lkp_match_s  = valid_r[age_idx_s[k]] && (tag_r[age_idx_s[k]] == lkp_tag_s);
            lkp_data_s   = lkp_match_s ? line_r[age_idx_s[k]] : lkp_data_s;
            lkp_hit_s    = lkp_hit_s | lkp_match_s;
        end
    end

    // FIFO bookkeeping; an entry leaves only on the B handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r    <= '0;
            tail_r    <= '0;
            count_r   <= '0;
            valid_r   <= '0;
            bus_err_r <= 1'b0;
        end else begin
            if (pop_s) begin
                head_r          <= head_r + PTR_W'(1);
                valid_r[head_r] <= 1'b0;
            end
            if (alloc_s) begin
                tail_r          <= tail_r + PTR_W'(1);
                valid_r[tail_r] <= 1'b1;
            end
            count_r <= count_r + CNT_W'(alloc_s) - CNT_W'(pop_s);
            if (pop_s && (bresp != 2'b00)) begin
                bus_err_r <= 1'b1;
            end
        end
    end

    // Line payload and tag storage; contents are qualified by valid_r.
    always_ff @(posedge clk) begin
        if (enq_fire_s) begin
            line_r[wr_idx_s] <= enq_data;
            tag_r[wr_idx_s]  <= enq_tag_s;
        end
    end

    // Drain FSM state and beat registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            beat_r  <= '0;
        end else begin
            state_r <= state_nxt_s;
            beat_r  <= beat_nxt_s;
        end
    end

    // Drain FSM next state: one burst at a time, AW strictly before W.
    always_comb begin
        state_nxt_s = state_r;
        beat_nxt_s  = beat_r;
        case (state_r)
            ST_IDLE: begin
                if (count_r != '0) begin
                    state_nxt_s = ST_AW;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_AW: begin
                if (awready) begin
                    state_nxt_s = ST_W;
                    beat_nxt_s  = '0;
                end else begin
                    state_nxt_s = ST_AW;
                end
            end
            ST_W: begin
                if (wready) begin
                    beat_nxt_s = beat_r + BEAT_W'(1);
                    if (beat_r == LAST_BEAT) begin
                        state_nxt_s = ST_B;
                    end else begin
                        state_nxt_s = ST_W;
                    end
                end else begin
                    state_nxt_s = ST_W;
                end
            end
            ST_B: begin
                if (bvalid) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_B;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                beat_nxt_s  = '0;
            end
        endcase
    end

    assign lookup_hit  = lkp_hit_s;
    assign lookup_data = lkp_data_s;
    assign empty       = (count_r == '0) && (state_r == ST_IDLE);
    assign bus_err     = bus_err_r;

    assign awid    = AXI_ID;
    assign awaddr  = {tag_r[head_r], {OFF_W{1'b0}}};
    assign awlen   = 8'(LINE_WORDS - 1);
    assign awsize  = 3'b010;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;
    assign awvalid = (state_r == ST_AW);

    assign wid    = AXI_ID;
    assign wdata  = line_r[head_r][beat_r];
    assign wstrb  = 4'hF;
    assign wlast  = (state_r == ST_W) && (beat_r == LAST_BEAT);
    assign wvalid = (state_r == ST_W);

    assign bready = (state_r == ST_B);

endmodule
